dpram_rw: RTL and testbench

DPRAM_RW -- requirements
Module: dpram_rw

---
 rtl/dpram_rw.sv | 48 ++++
 tb/tb_dpram_rw.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dpram_rw.sv
// Simple dual-port RAM: one write port, one registered read port.
// Same-address read and write on one edge returns the pre-write word.
module dpram_rw #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rd_en,
  input  logic [$clog2(DATA_DEPTH)-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]         rd_data,
  input  logic                          wr_en,
  input  logic [$clog2(DATA_DEPTH)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]         wr_data
);

  localparam int AW = $clog2(DATA_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(DATA_DEPTH);

  if (DATA_WIDTH < 1 || DATA_DEPTH < 2) begin : g_bad_params
    $error("dpram_rw: need DATA_WIDTH >= 1 and DATA_DEPTH >= 2");
  end

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

  logic wr_ok;
  logic rd_ok;

  // Depth need not be a power of two, so the top codes can be unmapped.
  assign wr_ok = ({1'b0, wr_addr} < DEPTH);
  assign rd_ok = ({1'b0, rd_addr} < DEPTH);

  // No reset on the array so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (rst && wr_en && wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_ok ? mem[rd_addr] : '0;
    end
  end

endmodule

// File: tb/tb_dpram_rw.sv
// Directed bench for dpram_rw: patterns, hold, read-before-write,
// reset behaviour and unmapped addresses on a non-power-of-two depth.
module tb_dpram_rw;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       wr_en = 1'b0;
  logic [7:0] wr_addr = '0;
  logic [7:0] wr_data = '0;

  logic       s_rd_en = 1'b0;
  logic [2:0] s_rd_addr = '0;
  logic [7:0] s_rd_data;
  logic       s_wr_en = 1'b0;
  logic [2:0] s_wr_addr = '0;
  logic [7:0] s_wr_data = '0;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] model [256];

  always #5 clk = ~clk;

  dpram_rw #(.DATA_WIDTH(8), .DATA_DEPTH(256)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  dpram_rw #(.DATA_WIDTH(8), .DATA_DEPTH(6)) u_small (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (s_rd_en),
    .rd_addr (s_rd_addr),
    .rd_data (s_rd_data),
    .wr_en   (s_wr_en),
    .wr_addr (s_wr_addr),
    .wr_data (s_wr_data)
  );

  task automatic check(input logic [7:0] obs, input logic [7:0] exp,
                       input string tag);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en = 1'b0;
    model[a] = d;
  endtask

  task automatic rd_chk(input logic [7:0] a, input logic [7:0] exp,
                        input string tag);
    rd_en = 1'b1;
    rd_addr = a;
    step();
    rd_en = 1'b0;
    check(rd_data, exp, tag);
  endtask

  initial begin
    logic [7:0] bytes4 [4];
    logic [7:0] v;
    bytes4 = '{8'hde, 8'had, 8'hbe, 8'hef};

    #2;
    check(rd_data, 8'h00, "reset_state");
    check(s_rd_data, 8'h00, "reset_state_small");
    #1;
    rst = 1'b1;

    // four bytes, then read each back
    for (int i = 0; i < 4; i++) wr(8'(i), bytes4[i]);
    rd_chk(8'd0, 8'hde, "b4_0");
    rd_chk(8'd1, 8'had, "b4_1");
    rd_chk(8'd2, 8'hbe, "b4_2");
    rd_chk(8'd3, 8'hef, "b4_3");

    // checkerboard across all words
    for (int i = 0; i < 256; i++) wr(8'(i), (i % 2 == 0) ? 8'h5a : 8'ha5);
    for (int i = 0; i < 256; i++)
      rd_chk(8'(i), (i % 2 == 0) ? 8'h5a : 8'ha5, "checker");

    // random fill
    for (int i = 0; i < 256; i++) wr(8'(i), 8'($urandom_range(0, 255)));
    for (int i = 0; i < 256; i++) rd_chk(8'(i), model[i], "random");

    // hold while rd_en=0, including a write to the word last read
    wr(8'd0, 8'h3e);
    rd_chk(8'd0, 8'h3e, "hold_load");
    for (int i = 0; i < 256; i++) begin
      rd_addr = 8'(i);
      if (i == 100) begin
        wr_en = 1'b1;
        wr_addr = 8'd0;
        wr_data = 8'hc1;
      end
      step();
      wr_en = 1'b0;
      check(rd_data, 8'h3e, "hold");
    end
    model[0] = 8'hc1;
    rd_chk(8'd0, 8'hc1, "hold_after_wr");

    // read-before-write on one edge
    wr(8'd128, 8'hff);
    wr_en = 1'b1;
    wr_addr = 8'd128;
    wr_data = 8'h5a;
    rd_en = 1'b1;
    rd_addr = 8'd128;
    step();
    wr_en = 1'b0;
    rd_en = 1'b0;
    check(rd_data, 8'hff, "rbw_old");
    rd_chk(8'd128, 8'h5a, "rbw_new");

    // same-edge read and write to different addresses
    wr(8'd40, 8'h11);
    wr(8'd41, 8'h22);
    wr_en = 1'b1;
    wr_addr = 8'd41;
    wr_data = 8'h99;
    rd_en = 1'b1;
    rd_addr = 8'd40;
    step();
    wr_en = 1'b0;
    rd_en = 1'b0;
    check(rd_data, 8'h11, "diff_rd");
    rd_chk(8'd41, 8'h99, "diff_wr");

    // async reset between edges, accesses ignored during reset
    wr(8'd10, 8'h3c);
    rd_chk(8'd10, 8'h3c, "pre_reset");
    #2;
    rst = 1'b0;
    #1;
    check(rd_data, 8'h00, "async_clear");
    wr_en = 1'b1;
    wr_addr = 8'd10;
    wr_data = 8'h77;
    rd_en = 1'b1;
    rd_addr = 8'd10;
    step();
    wr_en = 1'b0;
    rd_en = 1'b0;
    check(rd_data, 8'h00, "rd_in_reset");
    #2;
    rst = 1'b1;
    rd_chk(8'd10, 8'h3c, "post_reset");
    rd_chk(8'd128, 8'h5a, "post_reset_2");

    // unmapped addresses on a depth-6 instance
    s_wr_en = 1'b1;
    s_wr_addr = 3'd5;
    s_wr_data = 8'h33;
    step();
    s_wr_addr = 3'd6;
    s_wr_data = 8'h44;
    step();
    s_wr_en = 1'b0;
    s_rd_en = 1'b1;
    s_rd_addr = 3'd5;
    step();
    check(s_rd_data, 8'h33, "small_in_range");
    s_rd_addr = 3'd7;
    step();
    check(s_rd_data, 8'h00, "small_oob_7");
    s_rd_addr = 3'd5;
    step();
    v = s_rd_data;
    check(v, 8'h33, "small_reload");
    s_rd_addr = 3'd6;
    step();
    s_rd_en = 1'b0;
    check(s_rd_data, 8'h00, "small_oob_6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
